uart_reg_bridge: RTL and testbench
==================================

Name: uart_reg_bridge

Overview:
- Byte-stream command decoder that sits directly downstream of ft232r_hs.
- Consumes received bytes on ft232r_hs's rd_req/rd_data/rd_ack side and turns them into single-cycle register reads and writes on a simple internal register bus.
- Returns response bytes on ft232r_hs's wr_req/wr_data/wr_ack side.
- Gives host software register access over the FT232R serial link.

Parameters:
- DATA_W, 16: register data width; fixed at 16, sent as two bytes, MSB first.
- RD_TIMEOUT, 1024: cycles to wait for reg_rvalid after reg_re before substituting the error word.
- FRAME_TIMEOUT, 100000: idle cycles allowed between bytes of one write frame before the frame is abandoned.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_req  in  1  byte available; connects to ft232r_hs rd_req.
- rx_data  in  8  received byte; connects to ft232r_hs rd_data.
- rx_ack  out  1  one-cycle byte-accept pulse; connects to ft232r_hs rd_ack.
- tx_req  out  1  response byte valid; connects to ft232r_hs wr_req.
- tx_data  out  8  response byte; connects to ft232r_hs wr_data.
- tx_ack  in  1  byte taken; connects to ft232r_hs wr_ack.
- reg_addr  out  7  register address.
- reg_wdata  out  16  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  16  read data, valid with reg_rvalid.
- reg_rvalid  in  1  read data valid.
- err_timeout  out  1  one-cycle pulse on frame or read timeout.

Behaviour:
- Reset: all outputs are 0, state IDLE, rx_armed=1, counters 0.
- Frame format:
  - cmd[7]=1 is a write: cmd, dhi, dlo. Response is 8'hA5.
  - cmd[7]=0 is a read: cmd only. Response is rdata[15:8], then rdata[7:0].
  - cmd[6:0] is the address.
- Rx handshake:
  - A byte is accepted only when rx_req=1, rx_armed=1, and the FSM is in a byte-receiving state (IDLE, GET_DHI, GET_DLO).
  - On accept: rx_ack is high for exactly one cycle, rx_data is captured that cycle, and rx_armed clears.
  - rx_armed sets when rx_req is sampled 0.
  - In any other state, rx_req is left pending with no ack. This backpressure reaches ft232r_hs, which handles cts_n.
- Tx handshake:
  - tx_data is stable while tx_req=1.
  - tx_req drops on the edge where tx_ack is sampled 1.
  - The next tx_req may not rise until tx_ack is sampled 0.
- FSM:
  - IDLE: on accept, latch address. If cmd[7]=1, go to GET_DHI; otherwise go to RD_ISSUE.
  - GET_DHI: on accept, latch dhi and go to GET_DLO.
  - GET_DLO: on accept, latch dlo and go to WR_ISSUE.
  - WR_ISSUE: reg_we=1 for one cycle with reg_addr/reg_wdata valid; go to SEND_ACK.
  - SEND_ACK: tx 8'hA5; after the handshake completes, go to IDLE.
  - RD_ISSUE: reg_re=1 for one cycle; go to RD_WAIT.
  - RD_WAIT: reg_rvalid is sampled from the cycle after reg_re (minimum latency 1).
    - On reg_rvalid, capture reg_rdata and go to SEND_HI.
    - After RD_TIMEOUT cycles without reg_rvalid, capture 16'hDEAD, pulse err_timeout, and go to SEND_HI.
  - SEND_HI: tx the high byte, then SEND_LO.
  - SEND_LO: tx the low byte, then IDLE.
- Register strobes and timeouts:
  - reg_rvalid outside RD_WAIT is ignored.
  - reg_addr and reg_wdata hold their last values between strobes.
- Frame timeout:
  - The counter clears on every accepted byte and runs only in GET_DHI and GET_DLO.
  - On reaching FRAME_TIMEOUT: pulse err_timeout, return to IDLE, discard the partial frame, issue no reg_we.
- Simultaneity:
  - rx_req arriving during SEND_* or RD_WAIT waits.
  - A tx_ack without tx_req is ignored.
- Reset mid-operation takes effect immediately and asynchronously: tx_req, reg_we and reg_re drop, and the partial frame is lost.
- Throughput: the write response has its tx_req rise 2 cycles after the dlo accept (WR_ISSUE, then SEND_ACK).

Decomposition:
- Package uart_bridge_pkg holds:
  - the state enum;
  - CMD_WR_BIT=7;
  - ACK_BYTE=8'hA5;
  - RD_ERR_WORD=16'hDEAD;
  - the default timeout constants.
- Sub-module uart_bridge_tx_hs is the tx req/ack holder:
  - load strobe plus byte in, busy out;
  - owns tx_req, tx_data, and the wait-for-ack-low rule.

Test Plan:
1. Write: bytes 8'h85, 8'h12, 8'h34 → one reg_we pulse with reg_addr=7'h05 and reg_wdata=16'h1234; response byte 8'hA5; exactly three rx_ack pulses.
2. Read: byte 8'h05 with the register model returning 16'hBEEF after 3 cycles → reg_re is a single pulse; tx bytes 8'hBE then 8'hEF; each tx_req drops after tx_ack.
3. Read timeout: byte 8'h7F with no reg_rvalid → after RD_TIMEOUT cycles, err_timeout pulses once; tx bytes 8'hDE then 8'hAD.
4. Frame timeout: bytes 8'h81, 8'h55, then silence (FRAME_TIMEOUT=50 in the bench) → err_timeout at 50 cycles; no reg_we; the next frame 8'h81, 8'hAA, 8'hBB writes 16'hAABB.
5. Backpressure: rx_req held high with the next cmd while tx_ack is withheld for 20 cycles → no rx_ack until SEND_LO completes; the byte is then accepted exactly once.
6. Reset in GET_DLO: deassert rst_n mid-frame → all outputs 0 immediately; after release, 8'h02 reads address 2 correctly.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART register bridge: FSM state encoding,
// frame-format constants and default timeout values.
package uart_bridge_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GET_DHI  = 4'd1,
        ST_GET_DLO  = 4'd2,
        ST_WR_ISSUE = 4'd3,
        ST_SEND_ACK = 4'd4,
        ST_RD_ISSUE = 4'd5,
        ST_RD_WAIT  = 4'd6,
        ST_SEND_HI  = 4'd7,
        ST_SEND_LO  = 4'd8
    } bridge_state_e;

    localparam int          CMD_WR_BIT        = 7;
    localparam logic [7:0]  ACK_BYTE          = 8'hA5;
    localparam logic [15:0] RD_ERR_WORD       = 16'hDEAD;
    localparam int          DEF_RD_TIMEOUT    = 1024;
    localparam int          DEF_FRAME_TIMEOUT = 100000;

    // States in which an incoming byte may be accepted.
    function automatic logic is_rx_state(input bridge_state_e s);
        logic r;
        case (s)
            ST_IDLE, ST_GET_DHI, ST_GET_DLO: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_bridge_tx_hs.sv
// Transmit-side req/ack holder: latches one byte on load, holds tx_req until
// tx_ack, then refuses a new byte until tx_ack has been seen low again.
module uart_bridge_tx_hs (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       tx_ack,
    output logic       tx_req,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done
);

    logic       tx_req_r;
    logic       ack_wait_r;
    logic [7:0] tx_data_r;

    assign busy    = tx_req_r | (ack_wait_r & tx_ack);
    assign done    = tx_req_r & tx_ack;
    assign tx_req  = tx_req_r;
    assign tx_data = tx_data_r;

    // Request/ack handshake state and the held output byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_req_r   <= 1'b0;
            ack_wait_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else if (tx_req_r) begin
            if (tx_ack) begin
                tx_req_r   <= 1'b0;
                ack_wait_r <= 1'b1;
            end else begin
                tx_req_r   <= 1'b1;
            end
        end else if (load && !busy) begin
            tx_req_r   <= 1'b1;
            tx_data_r  <= load_byte;
            ack_wait_r <= 1'b0;
        end else if (!tx_ack) begin
            ack_wait_r <= 1'b0;
        end else begin
            ack_wait_r <= ack_wait_r;
        end
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-stream command decoder between the FT232R handshake and a simple
// register bus: write frames (cmd,dhi,dlo) answer 0xA5, read frames answer two bytes.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int RD_TIMEOUT    = DEF_RD_TIMEOUT,
    parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_req,
    input  logic [7:0]        rx_data,
    output logic              rx_ack,
    output logic              tx_req,
    output logic [7:0]        tx_data,
    input  logic              tx_ack,
    output logic [6:0]        reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_rvalid,
    output logic              err_timeout
);

    localparam int RD_CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam int FR_CNT_W = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [RD_CNT_W-1:0] RD_LAST = RD_CNT_W'(RD_TIMEOUT - 1);
    localparam logic [FR_CNT_W-1:0] FR_LAST = FR_CNT_W'(FRAME_TIMEOUT - 1);

    bridge_state_e     state_r, state_next_s;
    logic              rx_armed_r;
    logic              rx_ack_r;
    logic              accept_s;
    logic [6:0]        cmd_addr_r;
    logic [7:0]        dhi_r;
    logic [6:0]        reg_addr_r;
    logic [DATA_W-1:0] reg_wdata_r;
    logic              reg_we_r;
    logic              reg_re_r;
    logic [DATA_W-1:0] rdata_r;
    logic [RD_CNT_W-1:0] rd_cnt_r;
    logic [FR_CNT_W-1:0] frame_cnt_r;
    logic              err_timeout_r;
    logic              frame_to_s;
    logic              rd_to_s;
    logic              rvalid_hit_s;
    logic              tx_load_s;
    logic [7:0]        tx_byte_s;
    logic              tx_busy_s;
    logic              tx_done_s;

    assign accept_s    = rx_req & rx_armed_r & is_rx_state(state_r);
    assign rx_ack      = rx_ack_r;
    assign reg_addr    = reg_addr_r;
    assign reg_wdata   = reg_wdata_r;
    assign reg_we      = reg_we_r;
    assign reg_re      = reg_re_r;
    assign err_timeout = err_timeout_r;

    uart_bridge_tx_hs u_tx_hs (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tx_load_s),
        .load_byte (tx_byte_s),
        .tx_ack    (tx_ack),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .busy      (tx_busy_s),
        .done      (tx_done_s)
    );

    // Next-state decode, timeout detection and response byte selection.
    always_comb begin
        state_next_s = state_r;
        frame_to_s   = 1'b0;
        rd_to_s      = 1'b0;
        rvalid_hit_s = 1'b0;
        tx_load_s    = 1'b0;
        tx_byte_s    = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = rx_data[CMD_WR_BIT] ? ST_GET_DHI : ST_RD_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GET_DHI, ST_GET_DLO: begin
                if (accept_s) begin
                    state_next_s = (state_r == ST_GET_DHI) ? ST_GET_DLO : ST_WR_ISSUE;
                end else if (frame_cnt_r == FR_LAST) begin
                    frame_to_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_WR_ISSUE: state_next_s = ST_SEND_ACK;
            ST_RD_ISSUE: state_next_s = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (reg_rvalid) begin
                    rvalid_hit_s = 1'b1;
                    state_next_s = ST_SEND_HI;
                end else if (rd_cnt_r == RD_LAST) begin
                    rd_to_s      = 1'b1;
                    state_next_s = ST_SEND_HI;
                end else begin
                    state_next_s = ST_RD_WAIT;
                end
            end
            // The holder ignores load while busy, so load can stay high until done.
            ST_SEND_ACK: begin
                tx_load_s    = 1'b1;
                tx_byte_s    = ACK_BYTE;
                state_next_s = tx_done_s ? ST_IDLE : ST_SEND_ACK;
            end
            ST_SEND_HI: begin
                tx_load_s    = 1'b1;
                tx_byte_s    = rdata_r[15:8];
                state_next_s = tx_done_s ? ST_SEND_LO : ST_SEND_HI;
            end
            ST_SEND_LO: begin
                tx_load_s    = 1'b1;
                tx_byte_s    = rdata_r[7:0];
                state_next_s = tx_done_s ? ST_IDLE : ST_SEND_LO;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register, rx handshake and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            rx_armed_r    <= 1'b1;
            rx_ack_r      <= 1'b0;
            reg_we_r      <= 1'b0;
            reg_re_r      <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            rx_ack_r      <= accept_s;
            reg_we_r      <= (state_next_s == ST_WR_ISSUE);
            reg_re_r      <= (state_next_s == ST_RD_ISSUE);
            err_timeout_r <= frame_to_s | rd_to_s;
            if (accept_s) begin
                rx_armed_r <= 1'b0;
            end else if (!rx_req) begin
                rx_armed_r <= 1'b1;
            end else begin
                rx_armed_r <= rx_armed_r;
            end
        end
    end

    // Frame capture; bus address/data only change when a strobe is about to fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_addr_r  <= 7'h00;
            dhi_r       <= 8'h00;
            reg_addr_r  <= 7'h00;
            reg_wdata_r <= 16'h0000;
            rdata_r     <= 16'h0000;
        end else begin
            if (accept_s && state_r == ST_IDLE) begin
                cmd_addr_r <= rx_data[6:0];
                if (!rx_data[CMD_WR_BIT]) begin
                    reg_addr_r <= rx_data[6:0];
                end
            end
            if (accept_s && state_r == ST_GET_DHI) begin
                dhi_r <= rx_data;
            end
            if (accept_s && state_r == ST_GET_DLO) begin
                reg_addr_r  <= cmd_addr_r;
                reg_wdata_r <= {dhi_r, rx_data};
            end
            if (rvalid_hit_s) begin
                rdata_r <= reg_rdata;
            end else if (rd_to_s) begin
                rdata_r <= RD_ERR_WORD;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Read-wait and inter-byte frame counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_r    <= {RD_CNT_W{1'b0}};
            frame_cnt_r <= {FR_CNT_W{1'b0}};
        end else begin
            if (state_r == ST_RD_WAIT && !rvalid_hit_s && !rd_to_s) begin
                rd_cnt_r <= rd_cnt_r + RD_CNT_W'(1);
            end else begin
                rd_cnt_r <= {RD_CNT_W{1'b0}};
            end
            if ((state_r == ST_GET_DHI || state_r == ST_GET_DLO) && !accept_s && !frame_to_s) begin
                frame_cnt_r <= frame_cnt_r + FR_CNT_W'(1);
            end else begin
                frame_cnt_r <= {FR_CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Randomised scoreboard bench for uart_reg_bridge: a frame-level reference
// model queues expected bus writes/reads and tx bytes; monitors pop and compare.
module tb_uart_reg_bridge;

    localparam int RD_TO = 40;
    localparam int FR_TO = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_req, rx_ack, tx_req, tx_ack;
    logic [7:0]  rx_data, tx_data;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata;
    logic        reg_we, reg_re, reg_rvalid, err_timeout;

    uart_reg_bridge #(.DATA_W(16), .RD_TIMEOUT(RD_TO), .FRAME_TIMEOUT(FR_TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_req(rx_req), .rx_data(rx_data), .rx_ack(rx_ack),
        .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    logic [7:0]  exp_tx[$];
    logic [22:0] exp_wr[$];
    logic [6:0]  exp_rd[$];
    logic [15:0] exp_mem[128];
    logic [15:0] env_mem[128];
    int rd_lat = 1;
    bit no_resp = 1'b0;
    int force_delay = -1;
    int tx_done_cnt = 0, rx_ack_cnt = 0, err_cnt = 0, we_cnt = 0, re_cnt = 0;
    int bytes_sent = 0, writes_issued = 0;
    int last_ack_cyc = 0, err_cyc = 0, re_cyc = 0, req_rise_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // rx_ack / err_timeout pulse monitor
    initial forever begin
        @(negedge clk);
        if (rx_ack) begin rx_ack_cnt++; last_ack_cyc = cyc; end
        if (err_timeout) begin err_cnt++; err_cyc = cyc; end
    end

    // tx sink: random ack delay, pops expected byte at ack time
    initial begin
        bit seen = 1'b0;
        int cnt = 0, dly = 0;
        logic [7:0] held = 8'h00;
        tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_ack = 1'b0; seen = 1'b0; cnt = 0;
            end else if (tx_ack) begin
                chk("tx_req_drop", tx_req, 0);
                tx_ack = 1'b0; seen = 1'b0;
            end else if (tx_req) begin
                if (!seen) begin
                    seen = 1'b1; cnt = 0; held = tx_data; req_rise_cyc = cyc;
                    dly = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
                end
                if (cnt >= dly) begin
                    chk("tx_stable", tx_data, held);
                    chk("tx_expected", exp_tx.size() != 0, 1);
                    if (exp_tx.size() != 0) chk("tx_byte", tx_data, exp_tx.pop_front());
                    tx_ack = 1'b1;
                    tx_done_cnt++;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // register-bus model: memory, write checker, read responder with latency
    initial begin
        bit pend = 1'b0, prev_re = 1'b0, prev_we = 1'b0;
        int lcnt = 0;
        logic [6:0] paddr = 7'h00;
        reg_rvalid = 1'b0; reg_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                reg_rvalid = 1'b0; pend = 1'b0; prev_re = 1'b0; prev_we = 1'b0;
            end else begin
                reg_rvalid = 1'b0;
                reg_rdata  = 16'($urandom);
                if (pend) begin
                    lcnt--;
                    if (lcnt == 0) begin
                        reg_rvalid = 1'b1; reg_rdata = env_mem[paddr]; pend = 1'b0;
                    end
                end
                if (reg_we) begin
                    we_cnt++;
                    chk("we_single", prev_we, 0);
                    chk("wr_expected", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) chk("reg_write", {reg_addr, reg_wdata}, exp_wr.pop_front());
                    env_mem[reg_addr] = reg_wdata;
                end
                if (reg_re) begin
                    re_cnt++; re_cyc = cyc;
                    chk("re_single", prev_re, 0);
                    chk("rd_expected", exp_rd.size() != 0, 1);
                    if (exp_rd.size() != 0) chk("reg_read_addr", reg_addr, exp_rd.pop_front());
                    if (!no_resp) begin pend = 1'b1; lcnt = rd_lat; paddr = reg_addr; end
                end
                prev_re = reg_re; prev_we = reg_we;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        rx_data = b; rx_req = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rx_ack) begin got = 1'b1; break; end
        end
        chk("rx_ack_seen", got, 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_req = 1'b0; rx_data = 8'($urandom);
        @(negedge clk);
        bytes_sent++;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [15:0] d);
        exp_wr.push_back({a, d});
        exp_tx.push_back(8'hA5);
        exp_mem[a] = d;
        writes_issued++;
        send_byte({1'b1, a});
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    task automatic do_read(input logic [6:0] a, input int lat, input bit noresp);
        logic [15:0] d;
        d = noresp ? 16'hDEAD : exp_mem[a];
        rd_lat = lat; no_resp = noresp;
        exp_rd.push_back(a);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
        send_byte({1'b0, a});
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && exp_rd.size() == 0 && !tx_req && !tx_ack) begin ok = 1'b1; break; end
        end
        chk("drain", ok, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, w0, a0, t0;
        bit got;
        rst_n = 1'b0; rx_req = 1'b0; rx_data = 8'h00;
        for (int i = 0; i < 128; i++) begin
            exp_mem[i] = 16'($urandom); env_mem[i] = exp_mem[i];
        end
        exp_mem[5] = 16'hBEEF; env_mem[5] = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("reset_outs", {rx_ack, tx_req, tx_data, reg_addr, reg_wdata, reg_we, reg_re, err_timeout}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // read with 3-cycle register latency
        a0 = re_cnt;
        do_read(7'h05, 3, 1'b0);
        wait_idle();
        chk("read_re_count", re_cnt - a0, 1);

        // write 0x1234 to address 5, then read it back
        a0 = rx_ack_cnt; w0 = we_cnt;
        do_write(7'h05, 16'h1234);
        wait_idle();
        chk("write_rx_acks", rx_ack_cnt - a0, 3);
        chk("write_we_count", we_cnt - w0, 1);
        chk("write_tx_latency", req_rise_cyc - last_ack_cyc, 2);
        do_read(7'h05, 1, 1'b0);
        wait_idle();

        // read timeout
        e0 = err_cnt;
        do_read(7'h7F, 1, 1'b1);
        wait_idle();
        chk("rd_timeout_pulses", err_cnt - e0, 1);
        chk("rd_timeout_delay", (err_cyc - re_cyc >= RD_TO) && (err_cyc - re_cyc <= RD_TO + 2), 1);

        // frame timeout, then a clean frame
        e0 = err_cnt; w0 = we_cnt;
        send_byte(8'h81);
        send_byte(8'h55);
        for (int i = 0; i < 200 && err_cnt == e0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("frame_timeout_pulses", err_cnt - e0, 1);
        chk("frame_timeout_delay", (err_cyc - last_ack_cyc >= FR_TO) && (err_cyc - last_ack_cyc <= FR_TO + 2), 1);
        chk("frame_timeout_no_we", we_cnt - w0, 0);
        do_write(7'h01, 16'hAABB);
        wait_idle();
        do_read(7'h01, 2, 1'b0);
        wait_idle();

        // backpressure: next command waits for both response bytes
        force_delay = 20;
        do_read(7'($urandom_range(0, 126)), 2, 1'b0);
        t0 = tx_done_cnt; a0 = rx_ack_cnt;
        rd_lat = 1;
        exp_rd.push_back(7'h03);
        exp_tx.push_back(exp_mem[3][15:8]);
        exp_tx.push_back(exp_mem[3][7:0]);
        rx_data = 8'h03; rx_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rx_ack) begin got = 1'b1; break; end
        end
        chk("bp_ack_seen", got, 1);
        chk("bp_tx_before_ack", tx_done_cnt - t0, 2);
        force_delay = -1;
        repeat (3) @(negedge clk);
        rx_req = 1'b0;
        @(negedge clk);
        bytes_sent++;
        chk("bp_single_accept", rx_ack_cnt - a0, 1);
        wait_idle();

        // asynchronous reset in GET_DLO
        send_byte(8'h81);
        send_byte(8'h55);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", {rx_ack, tx_req, tx_data, reg_addr, reg_wdata, reg_we, reg_re, err_timeout}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(7'h02, 1, 1'b0);
        wait_idle();

        // randomised frames
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) do_write(7'($urandom), 16'($urandom));
            else do_read(7'($urandom), int'($urandom_range(1, 6)), 1'b0);
        end
        wait_idle();

        chk("end_tx_queue", exp_tx.size(), 0);
        chk("end_wr_queue", exp_wr.size(), 0);
        chk("end_rx_acks", rx_ack_cnt, bytes_sent);
        chk("end_we_count", we_cnt, writes_issued);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
